// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer MAC sequencer: FSM state encoding and
// default sizing of the scalar bus and weight-RAM address.
package layer_sequencer_pkg;

    // Pass phases: clear accumulators, stream inputs, wait for MAC, present result
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_INPUTS  = 4;
    localparam int unsigned DEF_BIT_WIDTH   = 32;
    localparam int unsigned DEF_EXTRA_BITS  = 2;
    localparam int unsigned DEF_MAC_LATENCY = 1;
    localparam int unsigned DEF_ADDR_WIDTH  = 8;

endpackage

// File: rtl/layer_sequencer.sv
// Sequences one LAYER MAC pass: clears the accumulators, streams NUM_INPUTS
// scalars from the input FIFO while reading one weight row per scalar, waits
// for the MAC pipeline to drain, then offers the result with valid/ready.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    pass request (IDLE only) / synchronous abort
//   busy            high whenever the sequencer is not idle
//   in_data         FIFO head scalar
//   in_empty        FIFO empty flag
//   in_pop          FIFO pop, combinational (head consumed on the same edge)
//   wt_rd_en        weight RAM read enable, combinational, with in_pop
//   wt_addr         weight row index, combinational, meaningful with wt_rd_en
//   l_input_scaler  registered scalar aligned with the RAM read data
//   l_acc_en        accumulate strobe, one cycle after each issue
//   l_clear         accumulator clear, one cycle at the start of a pass
//   out_valid       LAYER result is final
//   out_ready       consumer accepts the result
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int unsigned EXTRA_BITS  = DEF_EXTRA_BITS,
    parameter int unsigned MAC_LATENCY = DEF_MAC_LATENCY,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0] in_data,
    input  logic                            in_empty,
    output logic                            in_pop,
    output logic                            wt_rd_en,
    output logic [ADDR_WIDTH-1:0]           wt_addr,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0] l_input_scaler,
    output logic                            l_acc_en,
    output logic                            l_clear,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int unsigned KW = $clog2(NUM_INPUTS + 1);
    localparam int unsigned DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [KW-1:0] K_END  = KW'(NUM_INPUTS);
    localparam logic [DW-1:0] D_LAST = DW'(MAC_LATENCY - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] d_q, d_d;
    logic          issue;

    // Next-state, counters and the issue strobe
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        d_d     = d_q;
        issue   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                // k reaches K_END right after the last issue: that cycle carries
                // the final accumulate, so leave for DRAIN at its end.
                if (k_q == K_END) begin
                    d_d     = '0;
                    state_d = S_DRAIN;
                end else if (!in_empty) begin
                    issue = 1'b1;
                    k_d   = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (d_q == D_LAST) begin
                    d_d     = '0;
                    state_d = S_DONE;
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    k_d     = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including an issue in this cycle
        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            d_d     = '0;
            issue   = 1'b0;
        end
    end

    assign in_pop   = issue;
    assign wt_rd_en = issue;
    assign wt_addr  = ADDR_WIDTH'(k_q);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            d_q            <= '0;
            busy           <= 1'b0;
            l_clear        <= 1'b0;
            l_acc_en       <= 1'b0;
            out_valid      <= 1'b0;
            l_input_scaler <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            d_q       <= d_d;
            busy      <= (state_d != S_IDLE);
            l_clear   <= (state_d == S_CLEAR);
            out_valid <= (state_d == S_DONE);
            // Scalar lands together with the RAM read data one cycle after issue
            l_acc_en  <= issue;
            if (issue) l_input_scaler <= in_data;
        end
    end

endmodule
